// File: rtl/rx_pkt_parser_pkg.sv
// +--------------------------------------------------------------------------+
// | rx_pkt_parser_pkg : packet-type constants, payload lengths, FSM states    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package rx_pkt_parser_pkg;

    localparam logic [2:0] PKT_HB  = 3'b000;
    localparam logic [2:0] PKT_CHE = 3'b001;
    localparam logic [2:0] PKT_INV = 3'b010;

    localparam logic [3:0] LEN_HB  = 4'd8;
    localparam logic [3:0] LEN_CHE = 4'd2;
    localparam logic [3:0] LEN_INV = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
        S_CHECK   = 3'd2,
        S_DISCARD = 3'd3,
        S_COMMIT  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rx_pkt_parser_pkt_len_lut.sv
// +--------------------------------------------------------------------------+
// | pkt_len_lut : combinational packet type to payload length / valid decode  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pkt_len_lut
    import rx_pkt_parser_pkg::*;
(
    input  logic [2:0] pkt_type,
    output logic [3:0] pay_len,
    output logic       type_ok
);

    always_comb begin
        pay_len = 4'd0;
        type_ok = 1'b0;
        case (pkt_type)
            PKT_HB:  begin pay_len = LEN_HB;  type_ok = 1'b1; end
            PKT_CHE: begin pay_len = LEN_CHE; type_ok = 1'b1; end
            PKT_INV: begin pay_len = LEN_INV; type_ok = 1'b1; end
            default: begin pay_len = 4'd0;    type_ok = 1'b0; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rx_pkt_parser.sv
// +--------------------------------------------------------------------------+
// | rx_pkt_parser : byte-stream packet parser feeding myNodeInfo fields       |
// | Optional trailing XOR checksum byte enabled by macro PKT_CHECKSUM_EN.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module rx_pkt_parser
    import rx_pkt_parser_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 rx_last,
    output logic                 rx_ready,
    input  logic [15:0]          energy_in,
    output logic [2:0]           fPktType,
    output logic [15:0]          hops,
    output logic [15:0]          e_max,
    output logic [15:0]          e_min,
    output logic [15:0]          e_threshold,
    output logic [15:0]          ch_ID,
    output logic [15:0]          timeslot,
    output logic [15:0]          energy,
    output logic                 en_MNI,
    output logic                 pkt_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

`ifdef PKT_CHECKSUM_EN
    localparam logic CSUM_EN = 1'b1;
`else
    localparam logic CSUM_EN = 1'b0;
`endif

    state_t          state;
    logic [3:0]      cnt;
    logic [3:0]      len_r;
    logic [2:0]      type_r;
    logic [7:0]      csum;
    logic [7:0][7:0] shadow;
    logic [7:0][7:0] sh_nxt;
    logic [3:0]      lut_len;
    logic            lut_ok;
    logic            accept;
    logic            pay_final;
    logic            go_commit;

    pkt_len_lut u_len_lut (
        .pkt_type (rx_data[2:0]),
        .pay_len  (lut_len),
        .type_ok  (lut_ok)
    );

    assign rx_ready  = (state != S_COMMIT);
    assign accept    = rx_valid && rx_ready;
    assign pay_final = (cnt == (len_r - 4'd1));

    // Final byte is folded in here so the commit edge sees the whole payload.
    always_comb begin
        sh_nxt = shadow;
        if (accept && (state == S_PAYLOAD))
            sh_nxt[cnt[2:0]] = rx_data;
    end

    assign go_commit = accept && rx_last &&
        (((state == S_PAYLOAD) && pay_final && !CSUM_EN) ||
         ((state == S_CHECK) && (rx_data == csum) && CSUM_EN));

    always_ff @(posedge clk) begin
        if (nrst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            len_r       <= 4'd0;
            type_r      <= 3'd0;
            csum        <= 8'd0;
            shadow      <= '0;
            fPktType    <= 3'b111;
            hops        <= 16'd0;
            e_max       <= 16'd0;
            e_min       <= 16'd0;
            e_threshold <= 16'd0;
            ch_ID       <= 16'd0;
            timeslot    <= 16'd0;
            energy      <= 16'd0;
            en_MNI      <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            en_MNI  <= 1'b0;
            pkt_err <= 1'b0;
            shadow  <= sh_nxt;

            if (go_commit) begin
                en_MNI   <= 1'b1;
                fPktType <= type_r;
                energy   <= energy_in;
                case (type_r)
                    PKT_HB: begin
                        hops        <= {sh_nxt[0], sh_nxt[1]};
                        e_max       <= {sh_nxt[2], sh_nxt[3]};
                        e_min       <= {sh_nxt[4], sh_nxt[5]};
                        e_threshold <= {sh_nxt[6], sh_nxt[7]};
                    end
                    PKT_CHE: ch_ID <= {sh_nxt[0], sh_nxt[1]};
                    PKT_INV: begin
                        ch_ID    <= {sh_nxt[0], sh_nxt[1]};
                        timeslot <= {sh_nxt[2], sh_nxt[3]};
                    end
                    default: ;
                endcase
            end

            if (state == S_COMMIT) begin
                state <= S_IDLE;
            end else if (accept) begin
                case (state)
                    S_IDLE: begin
                        type_r <= rx_data[2:0];
                        len_r  <= lut_len;
                        cnt    <= 4'd0;
                        csum   <= rx_data;
                        if (rx_last)
                            pkt_err <= 1'b1;
                        else if (lut_ok)
                            state <= S_PAYLOAD;
                        else
                            state <= S_DISCARD;
                    end
                    S_PAYLOAD: begin
                        cnt  <= cnt + 4'd1;
                        csum <= csum ^ rx_data;
                        if (pay_final) begin
                            if (CSUM_EN) begin
                                if (rx_last) begin
                                    pkt_err <= 1'b1;
                                    state   <= S_IDLE;
                                end else begin
                                    state <= S_CHECK;
                                end
                            end else begin
                                state <= rx_last ? S_COMMIT : S_DISCARD;
                            end
                        end else if (rx_last) begin
                            pkt_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                    S_CHECK: begin
                        if (!rx_last) begin
                            state <= S_DISCARD;
                        end else if (rx_data == csum) begin
                            state <= S_COMMIT;
                        end else begin
                            pkt_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                    S_DISCARD: begin
                        if (rx_last) begin
                            pkt_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Counter trails the pkt_err pulse by one cycle and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (nrst)
            err_cnt <= '0;
        else if (pkt_err && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
    end

endmodule

`default_nettype wire

// File: tb/tb_rx_pkt_parser.sv
// +--------------------------------------------------------------------------+
// | tb_rx_pkt_parser : directed self-checking bench for rx_pkt_parser         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rx_pkt_parser;

    logic        clk;
    logic        nrst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic        rx_ready;
    logic [15:0] energy_in;
    logic [2:0]  fPktType;
    logic [15:0] hops, e_max, e_min, e_threshold, ch_ID, timeslot, energy;
    logic        en_MNI;
    logic        pkt_err;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    rx_pkt_parser #(.ERR_CNT_W(8)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_last     (rx_last),
        .rx_ready    (rx_ready),
        .energy_in   (energy_in),
        .fPktType    (fPktType),
        .hops        (hops),
        .e_max       (e_max),
        .e_min       (e_min),
        .e_threshold (e_threshold),
        .ch_ID       (ch_ID),
        .timeslot    (timeslot),
        .energy      (energy),
        .en_MNI      (en_MNI),
        .pkt_err     (pkt_err),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one clock edge, then sample 1 time unit later.
    task automatic send(input logic [7:0] d, input logic last);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_last  = last;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst      = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_last   = 1'b0;
        energy_in = 16'h8000;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;

        check("rst_fPktType", 32'(fPktType), 32'h7);
        check("rst_hops",     32'(hops),     32'h0);
        check("rst_ch_ID",    32'(ch_ID),    32'h0);
        check("rst_err_cnt",  32'(err_cnt),  32'h0);
        check("rst_en_MNI",   32'(en_MNI),   32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);

        // HB packet with a stall gap mid-payload (rx_last high while invalid)
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
        rx_data = 8'hFF; rx_last = 1'b1; idle_cycle(); idle_cycle(); rx_last = 1'b0;
        send(8'h80, 1'b0); send(8'h00, 1'b0); send(8'h40, 1'b0);
        send(8'h00, 1'b0); send(8'h33, 1'b0);
        check("hb_no_early_commit", 32'(en_MNI), 32'h0);
        energy_in = 16'h8000;
        send(8'h33, 1'b1);
        check("hb_en_MNI",      32'(en_MNI),      32'h1);
        check("hb_rx_ready",    32'(rx_ready),    32'h0);
        check("hb_fPktType",    32'(fPktType),    32'h0);
        check("hb_hops",        32'(hops),        32'h0001);
        check("hb_e_max",       32'(e_max),       32'h8000);
        check("hb_e_min",       32'(e_min),       32'h4000);
        check("hb_e_threshold", 32'(e_threshold), 32'h3333);
        check("hb_energy",      32'(energy),      32'h8000);
        idle_cycle();
        check("hb_en_MNI_pulse", 32'(en_MNI),   32'h0);
        check("hb_rx_ready_back", 32'(rx_ready), 32'h1);

        // CHE commit
        energy_in = 16'h1234;
        send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h0C, 1'b1);
        check("che_en_MNI",   32'(en_MNI),   32'h1);
        check("che_ch_ID",    32'(ch_ID),    32'h000C);
        check("che_hops",     32'(hops),     32'h0001);
        check("che_e_max",    32'(e_max),    32'h8000);
        check("che_fPktType", 32'(fPktType), 32'h1);
        check("che_energy",   32'(energy),   32'h1234);
        idle_cycle();

        // CHE truncated: last on payload byte 1
        send(8'h01, 1'b0); send(8'h00, 1'b1);
        check("short_pkt_err", 32'(pkt_err), 32'h1);
        check("short_en_MNI",  32'(en_MNI),  32'h0);
        idle_cycle();
        check("short_err_cnt", 32'(err_cnt), 32'h1);
        check("short_ch_ID",   32'(ch_ID),   32'h000C);
        check("short_pkt_err_clr", 32'(pkt_err), 32'h0);

        // Unknown type 05 then three bytes
        send(8'h05, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        check("unk_no_err_yet", 32'(pkt_err), 32'h0);
        send(8'hCC, 1'b1);
        check("unk_pkt_err", 32'(pkt_err), 32'h1);
        idle_cycle();
        check("unk_single_err", 32'(pkt_err), 32'h0);
        check("unk_err_cnt",    32'(err_cnt), 32'h2);
        check("unk_ch_ID",      32'(ch_ID),   32'h000C);
        check("unk_fPktType",   32'(fPktType), 32'h1);

        // HB whose final payload byte lacks rx_last: discarded to next last
        send(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) send(8'h11, 1'b0);
        check("hb_long_no_commit", 32'(en_MNI), 32'h0);
        send(8'h22, 1'b1);
        check("hb_long_pkt_err", 32'(pkt_err), 32'h1);
        idle_cycle();
        check("hb_long_hops", 32'(hops),    32'h0001);
        check("hb_long_cnt",  32'(err_cnt), 32'h3);

        // Reset after the 4th HB byte, then a clean INV packet
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h80, 1'b0);
        nrst = 1'b1;
        idle_cycle();
        nrst = 1'b0;
        check("mid_rst_pkt_err", 32'(pkt_err),  32'h0);
        check("mid_rst_err_cnt", 32'(err_cnt),  32'h0);
        check("mid_rst_fPkt",    32'(fPktType), 32'h7);
        send(8'h02, 1'b0); send(8'h00, 1'b0); send(8'h20, 1'b0);
        send(8'h00, 1'b0); send(8'h03, 1'b1);
        check("inv_en_MNI",   32'(en_MNI),   32'h1);
        check("inv_ch_ID",    32'(ch_ID),    32'h0020);
        check("inv_timeslot", 32'(timeslot), 32'h0003);
        check("inv_fPktType", 32'(fPktType), 32'h2);
        check("inv_hops",     32'(hops),     32'h0000);
        idle_cycle();
        check("inv_err_cnt",  32'(err_cnt),  32'h0);

        // Saturation: 258 single-byte drops (type byte carrying rx_last)
        for (int i = 0; i < 258; i++) send(8'h07, 1'b1);
        idle_cycle();
        check("sat_err_cnt", 32'(err_cnt), 32'hFF);
        check("sat_ch_ID",   32'(ch_ID),   32'h0020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx_pkt_parser.md
RX_PKT_PARSER -- requirements
Module: rx_pkt_parser

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the saturating dropped-packet counter.
REQ-002 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-003 SHALL have port nrst  input  1  synchronous, active-high reset (asserted = 1).
REQ-004 SHALL have port rx_valid  input  1  byte strobe from the radio/memory reader.
REQ-005 SHALL have port rx_data  input  8  packet byte, MSB-first fields.
REQ-006 SHALL have port rx_last  input  1  marks the final byte of a packet; qualified by rx_valid.
REQ-007 SHALL have port rx_ready  output  1  byte accept; a byte transfers when rx_valid && rx_ready.
REQ-008 SHALL have port energy_in  input  16  node residual energy, 14.2 fixed point.
REQ-009 SHALL have ports fPktType[3], hops[16], e_max[16], e_min[16], e_threshold[16], ch_ID[16], timeslot[16], energy[16]  output  committed fields for myNodeInfo.
REQ-010 SHALL have port en_MNI  output  1  one-cycle commit pulse to myNodeInfo.
REQ-011 SHALL have ports pkt_err  output  1  one-cycle drop pulse; err_cnt  output  ERR_CNT_W  dropped-packet count.

Function
REQ-012 Byte 0 SHALL be the type byte; fPktType = rx_data[2:0]; rx_data[7:3] ignored.
REQ-013 Payload lengths SHALL be: HB (000) 8 bytes = hops, e_max, e_min, e_threshold; CHE (001) 2 bytes = ch_ID; INV (010) 4 bytes = ch_ID, timeslot.
REQ-014 Types 011-111 SHALL be dropped.
REQ-015 FSM states SHALL be S_IDLE, S_PAYLOAD, S_CHECK, S_DISCARD, S_COMMIT.
REQ-016 S_IDLE: on an accepted type byte, go to S_PAYLOAD (known type, rx_last=0), S_DISCARD (unknown type, rx_last=0), or stay in S_IDLE with pkt_err (rx_last=1).
REQ-017 S_PAYLOAD: 4-bit byte counter; bytes go to shadow registers only; rx_last before the final payload byte -> pkt_err, S_IDLE.
REQ-018 Final payload byte with rx_last=1 -> S_COMMIT (or S_CHECK when checksum is enabled and rx_last=0); rx_last=0 without checksum -> S_DISCARD.
REQ-019 S_DISCARD: accept and ignore bytes until an rx_last byte, then pulse pkt_err and go to S_IDLE.
REQ-020 S_COMMIT: rx_ready=0; copy shadows and energy_in into the outputs; en_MNI=1 for exactly this cycle; go to S_IDLE.
REQ-021 rx_ready SHALL be 1 in every state except S_COMMIT.
REQ-022 Latency: en_MNI SHALL assert the cycle after the last byte is accepted.
REQ-023 Outputs SHALL change only in S_COMMIT; only the fields carried by the type are updated, other fields hold.
REQ-024 Dropped packets SHALL leave all field outputs unchanged.
REQ-025 err_cnt SHALL increment on every pkt_err and saturate at all-ones.
REQ-026 rx_valid=0 SHALL stall the FSM with no state change (no timeout).

Reset
REQ-027 nrst SHALL force S_IDLE, zero the counter and shadows, and clear all field outputs, en_MNI, pkt_err and err_cnt to 0, except fPktType = 3'b111.
REQ-028 Reset mid-packet SHALL abandon the packet without pkt_err; the next accepted byte is a type byte.

Configuration
REQ-029 Macro PKT_CHECKSUM_EN: when defined, a trailing checksum byte SHALL follow the payload (S_CHECK), equal to the XOR of all preceding bytes.
REQ-030 With PKT_CHECKSUM_EN, a mismatch or a missing rx_last on the checksum byte SHALL drop the packet with pkt_err; when not defined, S_CHECK is unreachable and packets carry no checksum.

Structure
REQ-031 A shared package SHALL hold the packet-type constants (PKT_HB, PKT_CHE, PKT_INV), the payload lengths and the state encoding; myNodeInfo uses the same type constants.
REQ-032 There SHALL be one sub-module, pkt_len_lut, a combinational type-to-length and type-valid decoder.

Verification
REQ-033 HB bytes 00,00,01,80,00,40,00,33,33 (last), energy_in=8000 -> en_MNI one cycle later; hops=0001, e_max=8000, e_min=4000, e_threshold=3333, energy=8000, fPktType=000.
REQ-034 CHE 01,00,0C (last) -> ch_ID=000C, while hops and e_max keep their HB values.
REQ-035 CHE 01,00 with last on byte 2 -> pkt_err pulse, err_cnt+1, no en_MNI, ch_ID unchanged.
REQ-036 Type 05 followed by 3 bytes (last on the 3rd) -> discard, single pkt_err, outputs unchanged.
REQ-037 nrst=1 after the 4th HB byte, then a full INV 02,00,20,00,03 (last) -> ch_ID=0020, timeslot=0003, err_cnt unchanged.
REQ-038 With PKT_CHECKSUM_EN: CHE 01,00,0C,0D (last) -> commit; checksum 0E -> pkt_err; 2^ERR_CNT_W+1 drops -> err_cnt stays at all-ones.
